btn_event_arbiter: RTL and testbench
====================================

# btn_event_arbiter

Collects single-cycle press pulses from up to `N_BTN` debouncer instances. It buffers them in per-button saturating pending counters and serialises them into one event stream with a valid/ready handshake, using round-robin arbitration. It sits between the per-button debouncers and the game/UI control FSM, so simultaneous or auto-repeat presses are never lost silently and never reach the consumer two at once.

## Interface
Parameters:
- `N_BTN`, default 4: number of button inputs, 2..8.
- `MAX_PEND`, default 3: per-button pending-event capacity, 1..15.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high reset.
- `btn_pulse`, input, `N_BTN`: one-cycle press pulses, one bit per debouncer output.
- `btn_mask`, input, `N_BTN`: 1 = button enabled, 0 = button ignored and its pending count flushed.
- `evt_ready`, input, 1: consumer accepts the event this cycle.
- `evt_valid`, output, 1: an event is presented.
- `evt_id`, output, `$clog2(N_BTN)`: index of the button for the presented event.
- `pending`, output, `N_BTN`: bit i = 1 when `cnt[i] != 0`.
- `ovf`, output, `N_BTN`: sticky per-button overflow flag.
- `ovf_clr`, input, 1: clears all `ovf` bits.

## Operation
- Per-button counter `cnt[i]` is `$clog2(MAX_PEND+1)` bits wide. It is registered and starts at 0.
- `inc[i]` = `btn_pulse[i] & btn_mask[i]`.
- `dec[i]` = 1 when button i is granted into the output register this cycle.
- Counter update priority:
  - `~btn_mask[i]` → `cnt[i] <= 0`.
  - `inc & ~dec` and `cnt < MAX_PEND` → `cnt + 1`.
  - `inc & ~dec` and `cnt == MAX_PEND` → counter unchanged and `ovf[i] <= 1`.
  - `~inc & dec` → `cnt - 1`.
  - `inc & dec`, or neither → counter unchanged, no overflow.
- Output register (`evt_valid`, `evt_id`) loads when `load` = `~evt_valid | evt_ready`.
  - On load, if any `cnt[i] != 0` (registered values), grant the first requester at or after `rr_ptr`, searching cyclically upward. Set `evt_id` to the granted index, set `evt_valid` to 1, and set `rr_ptr` to the granted index + 1, wrapping from `N_BTN-1` to 0.
  - On load with no requesters: `evt_valid <= 0`. `evt_id` and `rr_ptr` hold.
  - Requests come from registered counts only. A pulse arriving in the current cycle is never granted in the same cycle.
- Holding: while `evt_valid & ~evt_ready`, `evt_valid` and `evt_id` stay stable and no grant occurs.
- Masking does not retract an event already in the output register.
- `ovf` is sticky. `ovf_clr` clears all bits. If `ovf_clr` and a new overflow occur in the same cycle, the new overflow wins and the bit ends at 1.
- Reset values: `cnt` = 0, `evt_valid` = 0, `evt_id` = 0, `rr_ptr` = 0, `ovf` = 0. Consequently `pending` = 0.
- A reset in the middle of a handshake discards the presented event and all pending counts. There is no partial state.

## Timing
- Pulse in cycle 0 → `cnt` = 1 after edge 1 → `evt_valid` = 1 after edge 2, if the output register was free or being consumed. Minimum latency is 2 cycles.
- Throughput: one event per cycle when `evt_ready` is held high and requests remain.
- A grant and the decrement of that button's counter happen on the same edge.
- `pending` and `ovf` are registered-state decodes with no added latency.
- `evt_id` is valid only while `evt_valid` = 1.

## Test plan
- Reset/idle: assert `reset` for 2 cycles with `btn_pulse` = 4'b1111 → `evt_valid` = 0, `cnt` = 0, `ovf` = 0 after release.
- Single press: pulse bit 2 in cycle 0 with `evt_ready` = 1 → `evt_valid` = 1 and `evt_id` = 2 after edge 2. After edge 3, `evt_valid` = 0 and `pending` = 0.
- Round-robin: pulse 4'b1111 in one cycle with `evt_ready` = 1 → `evt_id` sequence 0,1,2,3 on consecutive cycles. A second 4'b1111 burst issued after `evt_id` = 1 is granted → sequence continues 2,3,0,1.
- Backpressure/overflow, `MAX_PEND` = 3, `evt_ready` = 0: pulse button 1 five times.
  - First pulse loads the output (`evt_id` = 1); `cnt[1]` ends at 3; `ovf[1]` = 1.
  - Raise `evt_ready` → exactly 4 events with id 1 are delivered.
  - Pulse `ovf_clr` → `ovf` = 0.
- Simultaneous inc/dec: `cnt[0]` = 3 at saturation, a grant of button 0 and a pulse on button 0 in the same cycle → `cnt[0]` stays 3 and `ovf[0]` stays 0.
- Mask flush: `cnt[3]` = 2 and button 3 is presented, then drop `btn_mask[3]` → `cnt[3]` = 0 next edge. The presented id 3 stays until accepted, then `evt_valid` = 0. Pulses on bit 3 while it is masked are ignored.

Source files
------------

// File: rtl/btn_event_arbiter.sv
// Buffers per-button press pulses in saturating pending counters and serialises
// them onto one valid/ready event stream with round-robin arbitration.
module btn_event_arbiter #(
    parameter int N_BTN    = 4,
    parameter int MAX_PEND = 3,
    localparam int IDW     = $clog2(N_BTN),
    localparam int CW      = $clog2(MAX_PEND + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_pulse,
    input  logic [N_BTN-1:0] btn_mask,
    input  logic             evt_ready,
    output logic             evt_valid,
    output logic [IDW-1:0]   evt_id,
    output logic [N_BTN-1:0] pending,
    output logic [N_BTN-1:0] ovf,
    input  logic             ovf_clr
);

    // Handshake: an event transfers on a rising edge where evt_valid & evt_ready;
    // while evt_valid & ~evt_ready the presented evt_id is held stable.

    logic [CW-1:0]    cnt_q [N_BTN];
    logic [CW-1:0]    cnt_d [N_BTN];
    logic [N_BTN-1:0] ovf_q, ovf_d, ovf_set;
    logic [N_BTN-1:0] req, inc, dec;
    logic             evt_valid_q, evt_valid_d;
    logic [IDW-1:0]   evt_id_q, evt_id_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   gnt_idx;
    logic             gnt_any;
    logic             load;

    assign load = ~evt_valid_q | evt_ready;

    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            req[i] = (cnt_q[i] != '0);
        end
    end

    // Cyclic search starting at rr_ptr; only registered counts can request.
    always_comb begin
        logic [IDW:0]   sum;
        logic [IDW-1:0] idx;
        gnt_any = 1'b0;
        gnt_idx = '0;
        sum     = '0;
        idx     = '0;
        for (int k = 0; k < N_BTN; k++) begin
            sum = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N_BTN)) begin
                sum = sum - (IDW+1)'(N_BTN);
            end
            idx = sum[IDW-1:0];
            if (!gnt_any && req[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    always_comb begin
        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (load) begin
            evt_valid_d = gnt_any;
            if (gnt_any) begin
                evt_id_d = gnt_idx;
                rr_ptr_d = (gnt_idx == IDW'(N_BTN - 1)) ? '0 : gnt_idx + IDW'(1);
            end
        end
    end

    // Mask flush dominates; a simultaneous press and grant cancel out.
    always_comb begin
        for (int i = 0; i < N_BTN; i++) begin
            inc[i]     = btn_pulse[i] & btn_mask[i];
            dec[i]     = load & gnt_any & (gnt_idx == IDW'(i));
            cnt_d[i]   = cnt_q[i];
            ovf_set[i] = 1'b0;
            if (!btn_mask[i]) begin
                cnt_d[i] = '0;
            end else if (inc[i] && !dec[i]) begin
                if (cnt_q[i] == CW'(MAX_PEND)) begin
                    ovf_set[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end else if (!inc[i] && dec[i]) begin
                cnt_d[i] = cnt_q[i] - CW'(1);
            end
        end
        ovf_d = (ovf_clr ? '0 : ovf_q) | ovf_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= '0;
            end
            ovf_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf_q       <= ovf_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign evt_valid = evt_valid_q;
    assign evt_id    = evt_id_q;
    assign pending   = req;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed scenarios for btn_event_arbiter; expected event ids are queued as
// stimulus is driven and popped at every completed handshake.
module tb_btn_event_arbiter;

    localparam int N_BTN    = 4;
    localparam int MAX_PEND = 3;
    localparam int IDW      = $clog2(N_BTN);

    logic             clk;
    logic             reset;
    logic [N_BTN-1:0] btn_pulse;
    logic [N_BTN-1:0] btn_mask;
    logic             evt_ready;
    logic             evt_valid;
    logic [IDW-1:0]   evt_id;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] ovf;
    logic             ovf_clr;

    int n_checks = 0;
    int n_errors = 0;
    logic [IDW-1:0] exp_q[$];

    btn_event_arbiter #(.N_BTN(N_BTN), .MAX_PEND(MAX_PEND)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_pulse (btn_pulse),
        .btn_mask  (btn_mask),
        .evt_ready (evt_ready),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .pending   (pending),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset     = 1'b0;
        btn_pulse = '0;
        exp_q.delete();
    endtask

    task automatic pulse_gap(input logic [N_BTN-1:0] b);
        btn_pulse = b;
        tick();
        btn_pulse = '0;
        tick();
    endtask

    task automatic push_n(input logic [IDW-1:0] id, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(id);
    endtask

    // scoreboard: a transfer completes on the next rising edge
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            check_val("evt_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check_val("evt_id", 32'(evt_id), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        reset     = 1'b1;
        btn_pulse = '1;
        btn_mask  = '1;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;

        // reset with all buttons pulsing
        tick();
        tick();
        reset     = 1'b0;
        btn_pulse = '0;
        check_val("rst_valid", 32'(evt_valid), 32'd0);
        check_val("rst_pending", 32'(pending), 32'd0);
        check_val("rst_ovf", 32'(ovf), 32'd0);
        tick();
        check_val("idle_valid", 32'(evt_valid), 32'd0);

        // single press, two-cycle latency
        push_n(2'd2, 1);
        btn_pulse = 4'b0100;
        tick();
        btn_pulse = '0;
        check_val("sp_pending1", 32'(pending), 32'h4);
        check_val("sp_valid1", 32'(evt_valid), 32'd0);
        tick();
        check_val("sp_valid2", 32'(evt_valid), 32'd1);
        check_val("sp_id2", 32'(evt_id), 32'd2);
        check_val("sp_pending2", 32'(pending), 32'd0);
        tick();
        check_val("sp_valid3", 32'(evt_valid), 32'd0);
        check_val("sp_pending3", 32'(pending), 32'd0);
        check_val("sp_drained", 32'(exp_q.size()), 32'd0);

        // round robin with a second burst arriving mid-sequence
        do_reset();
        evt_ready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int b = 0; b < N_BTN; b++) exp_q.push_back(IDW'(b));
        btn_pulse = 4'b1111;
        tick();
        btn_pulse = '0;
        tick();
        check_val("rr_id0", 32'(evt_id), 32'd0);
        tick();
        check_val("rr_id1", 32'(evt_id), 32'd1);
        btn_pulse = 4'b1111;
        tick();
        btn_pulse = '0;
        check_val("rr_id2", 32'(evt_id), 32'd2);
        check_val("rr_valid_run", 32'(evt_valid), 32'd1);
        wait_cycles(7);
        check_val("rr_drained", 32'(exp_q.size()), 32'd0);
        check_val("rr_valid_end", 32'(evt_valid), 32'd0);
        check_val("rr_pending_end", 32'(pending), 32'd0);

        // backpressure and overflow on button 1
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 5; i++) pulse_gap(4'b0010);
        check_val("bp_valid", 32'(evt_valid), 32'd1);
        check_val("bp_id", 32'(evt_id), 32'd1);
        check_val("bp_pending", 32'(pending), 32'h2);
        check_val("bp_ovf", 32'(ovf), 32'h2);
        btn_pulse = 4'b0010;
        ovf_clr   = 1'b1;
        tick();
        btn_pulse = '0;
        ovf_clr   = 1'b0;
        check_val("ovf_set_beats_clr", 32'(ovf), 32'h2);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_val("ovf_cleared", 32'(ovf), 32'd0);
        check_val("bp_id_held", 32'(evt_id), 32'd1);
        push_n(2'd1, 4);
        for (int i = 0; i < 16; i++) begin
            evt_ready = 1'($urandom_range(0, 1));
            tick();
        end
        evt_ready = 1'b1;
        wait_cycles(8);
        check_val("bp_drained", 32'(exp_q.size()), 32'd0);
        check_val("bp_valid_end", 32'(evt_valid), 32'd0);
        check_val("bp_ovf_end", 32'(ovf), 32'd0);

        // grant and press of a saturated button on the same edge
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 4; i++) pulse_gap(4'b0001);
        check_val("sim_pending", 32'(pending), 32'h1);
        check_val("sim_ovf_pre", 32'(ovf), 32'd0);
        push_n(2'd0, 1);
        evt_ready = 1'b1;
        btn_pulse = 4'b0001;
        tick();
        evt_ready = 1'b0;
        btn_pulse = '0;
        check_val("sim_ovf", 32'(ovf), 32'd0);
        check_val("sim_valid", 32'(evt_valid), 32'd1);
        check_val("sim_id", 32'(evt_id), 32'd0);
        push_n(2'd0, 4);
        evt_ready = 1'b1;
        wait_cycles(8);
        check_val("sim_drained", 32'(exp_q.size()), 32'd0);
        check_val("sim_pending_end", 32'(pending), 32'd0);

        // mask flush keeps the presented event
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) pulse_gap(4'b1000);
        check_val("mf_pending_pre", 32'(pending), 32'h8);
        btn_mask = 4'b0111;
        tick();
        check_val("mf_flushed", 32'(pending), 32'd0);
        check_val("mf_valid", 32'(evt_valid), 32'd1);
        check_val("mf_id", 32'(evt_id), 32'd3);
        pulse_gap(4'b1000);
        check_val("mf_masked_press", 32'(pending), 32'd0);
        check_val("mf_ovf", 32'(ovf), 32'd0);
        push_n(2'd3, 1);
        evt_ready = 1'b1;
        tick();
        check_val("mf_valid_end", 32'(evt_valid), 32'd0);
        pulse_gap(4'b1000);
        tick();
        check_val("mf_still_idle", 32'(evt_valid), 32'd0);
        check_val("mf_drained", 32'(exp_q.size()), 32'd0);
        btn_mask = '1;

        // reset in the middle of a stalled handshake
        evt_ready = 1'b0;
        for (int i = 0; i < 3; i++) pulse_gap(4'b0100);
        do_reset();
        check_val("mr_valid", 32'(evt_valid), 32'd0);
        check_val("mr_pending", 32'(pending), 32'd0);
        evt_ready = 1'b1;
        wait_cycles(3);
        check_val("mr_idle", 32'(evt_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
